// File: rtl/echo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : echo_pkg
// Brief    : Shared constants, header layout and FSM encoding for echo_indication_tx
// Revision : 1.0
// ============================================================================
package echo_pkg;

    localparam logic [15:0] c_METHOD_ID_DFLT = 16'h0001;
    localparam logic [15:0] c_HDR_LEN        = 16'd2;
    localparam int          c_HDR_ID_LSB     = 16;
    localparam int          c_HDR_LEN_LSB    = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2
    } state_t;

    // Portal header: method number in the upper half, word count (incl. header) in the lower half
    function automatic logic [31:0] f_header(input logic [15:0] i_method_id);
        logic [31:0] w_hdr;
        w_hdr = '0;
        w_hdr[c_HDR_ID_LSB  +: 16] = i_method_id;
        w_hdr[c_HDR_LEN_LSB +: 16] = c_HDR_LEN;
        return w_hdr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO with extra-MSB pointers; head is show-ahead
// Revision : 1.0
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_din,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int c_AW = $clog2(DEPTH);

    logic [c_AW:0]      r_wr_ptr;
    logic [c_AW:0]      r_rd_ptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_push;
    logic               w_pop;

    assign o_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_level = r_wr_ptr - r_rd_ptr;
    assign o_head  = r_mem[r_rd_ptr[c_AW-1:0]];

    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop  & ~o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: pointers alone define which entries are live
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_din;
    end

endmodule
`default_nettype wire

// File: rtl/echo_indication_tx.sv
`default_nettype none
// ============================================================================
// Module   : echo_indication_tx
// Brief    : Buffers echo(v) indications and streams each as a header+payload portal message
// Revision : 1.0
// ============================================================================
module echo_indication_tx
    import echo_pkg::*;
#(
    parameter int          DEPTH      = 4,
    parameter logic [15:0] METHOD_ID  = c_METHOD_ID_DFLT,
    parameter logic [15:0] STOP_COUNT = 16'd1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        echo__ENA,
    input  logic [31:0] echo_v,
    output logic        echo__RDY,
    output logic        msg_valid,
    output logic [31:0] msg_data,
    output logic        msg_last,
    input  logic        msg_ready,
    output logic [15:0] msg_count,
    output logic        stop_main_program,
    output logic        proto_err
);

    localparam int            c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0] c_LVL_ONE = {{c_AW{1'b0}}, 1'b1};
    localparam logic [31:0]   c_HEADER  = f_header(METHOD_ID);

    logic           w_full;
    logic           w_empty;
    logic [31:0]    w_head;
    logic [c_AW:0]  w_level;
    logic           w_push;
    logic           w_pop;
    logic           w_more;
    logic           w_pay_hs;
    logic [15:0]    w_count_inc;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_valid;
    logic           w_valid_nxt;
    logic [31:0]    r_data;
    logic [31:0]    w_data_nxt;
    logic           r_last;
    logic           w_last_nxt;
    logic [15:0]    r_count;
    logic           r_stop;
    logic           r_err;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (nRST),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (echo_v),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head),
        .o_level (w_level)
    );

    assign echo__RDY   = ~w_full;
    assign w_push      = echo__ENA & ~w_full;
    // A push landing on the payload pop edge still counts as "more", avoiding a bubble
    assign w_more      = (w_level != c_LVL_ONE) | w_push;
    assign w_pay_hs    = (r_state == PAY) & msg_ready;
    assign w_count_inc = r_count + 16'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_valid;
        w_data_nxt  = r_data;
        w_last_nxt  = r_last;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                w_valid_nxt = 1'b0;
                if (!w_empty) begin
                    w_state_nxt = HDR;
                    w_valid_nxt = 1'b1;
                    w_data_nxt  = c_HEADER;
                    w_last_nxt  = 1'b0;
                end
            end
            HDR: begin
                if (msg_ready) begin
                    w_state_nxt = PAY;
                    w_data_nxt  = w_head;
                    w_last_nxt  = 1'b1;
                end
            end
            PAY: begin
                if (msg_ready) begin
                    w_pop      = 1'b1;
                    w_last_nxt = 1'b0;
                    if (w_more) begin
                        w_state_nxt = HDR;
                        w_data_nxt  = c_HEADER;
                    end else begin
                        w_state_nxt = IDLE;
                        w_valid_nxt = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_valid_nxt = 1'b0;
                w_last_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_valid_nxt;
            r_data  <= w_data_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_count <= '0;
            r_stop  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_pay_hs) begin
                r_count <= w_count_inc;
                if ((STOP_COUNT != 16'd0) && (w_count_inc == STOP_COUNT))
                    r_stop <= 1'b1;
            end
            if (echo__ENA & w_full)
                r_err <= 1'b1;
        end
    end

    assign msg_valid         = r_valid;
    assign msg_data          = r_data;
    assign msg_last          = r_last;
    assign msg_count         = r_count;
    assign stop_main_program = r_stop;
    assign proto_err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_echo_indication_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_echo_indication_tx
// Brief    : Directed + randomised-stall scoreboard bench for echo_indication_tx
// Revision : 1.0
// ============================================================================
module tb_echo_indication_tx;

    localparam logic [31:0] c_HDR = 32'h0001_0002;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        echo__ENA = 1'b0;
    logic [31:0] echo_v = '0;
    logic        echo__RDY;
    logic        msg_valid;
    logic [31:0] msg_data;
    logic        msg_last;
    logic        msg_ready = 1'b0;
    logic [15:0] msg_count;
    logic        stop_main_program;
    logic        proto_err;

    logic        e3 = 1'b0;
    logic [31:0] v3 = '0;
    logic        rdy3;
    logic        valid3;
    logic [31:0] data3;
    logic        last3;
    logic        ready3 = 1'b1;
    logic [15:0] count3;
    logic        stop3;
    logic        err3;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [32:0] q[$];
    logic        r_prev_stall = 1'b0;
    logic [32:0] r_prev_word  = '0;

    always #5 CLK = ~CLK;

    echo_indication_tx #(.DEPTH(4), .METHOD_ID(16'h0001), .STOP_COUNT(16'd1)) u_dut (
        .CLK(CLK), .nRST(nRST), .echo__ENA(echo__ENA), .echo_v(echo_v), .echo__RDY(echo__RDY),
        .msg_valid(msg_valid), .msg_data(msg_data), .msg_last(msg_last), .msg_ready(msg_ready),
        .msg_count(msg_count), .stop_main_program(stop_main_program), .proto_err(proto_err)
    );

    echo_indication_tx #(.DEPTH(4), .METHOD_ID(16'h0001), .STOP_COUNT(16'd3)) u_dut3 (
        .CLK(CLK), .nRST(nRST), .echo__ENA(e3), .echo_v(v3), .echo__RDY(rdy3),
        .msg_valid(valid3), .msg_data(data3), .msg_last(last3), .msg_ready(ready3),
        .msg_count(count3), .stop_main_program(stop3), .proto_err(err3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard: the word is accepted at the next rising edge if valid & ready now
    always @(negedge CLK) begin
        if (nRST) begin
            if (r_prev_stall)
                chk("stall_hold", {msg_valid, msg_last, msg_data}, {1'b1, r_prev_word});
            if (msg_valid && msg_ready) begin
                if (q.size() == 0)
                    chk("unexpected_word", {msg_last, msg_data}, 33'h1_FFFF_FFFF);
                else
                    chk("stream_word", {msg_last, msg_data}, q.pop_front());
            end
            r_prev_stall = msg_valid && !msg_ready;
            r_prev_word  = {msg_last, msg_data};
        end else begin
            r_prev_stall = 1'b0;
        end
    end

    task automatic push(input logic [31:0] val);
        int i;
        for (i = 0; i < 100 && !echo__RDY; i++) tick();
        if (!echo__RDY) chk("push_rdy_timeout", {63'd0, echo__RDY}, 64'd1);
        echo__ENA = 1'b1;
        echo_v    = val;
        q.push_back({1'b0, c_HDR});
        q.push_back({1'b1, val});
        tick();
        echo__ENA = 1'b0;
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 300 && q.size() != 0; i++) tick();
        chk("drain_left", 64'(q.size()), 64'd0);
        tick();
        tick();
    endtask

    task automatic wait_cnt(input logic [15:0] target);
        int i;
        for (i = 0; i < 50 && msg_count != target; i++) tick();
        chk("cnt_wait", {48'd0, msg_count}, {48'd0, target});
    endtask

    task automatic do_reset();
        nRST      = 1'b0;
        echo__ENA = 1'b0;
        e3        = 1'b0;
        tick();
        tick();
        q.delete();
        nRST = 1'b1;
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int npush;
        int i;
        int k;

        // Reset values while nRST is held low
        tick();
        chk("rst_valid", {63'd0, msg_valid}, 64'd0);
        chk("rst_data", {32'd0, msg_data}, 64'd0);
        chk("rst_last", {63'd0, msg_last}, 64'd0);
        chk("rst_count", {48'd0, msg_count}, 64'd0);
        chk("rst_stop", {63'd0, stop_main_program}, 64'd0);
        chk("rst_err", {63'd0, proto_err}, 64'd0);
        nRST = 1'b1;
        tick();
        chk("rst_rdy", {63'd0, echo__RDY}, 64'd1);

        // Single echo(22), latency and stop with STOP_COUNT=1
        msg_ready = 1'b1;
        push(32'd22);
        chk("lat_pre_valid", {63'd0, msg_valid}, 64'd0);
        tick();
        chk("lat_hdr_valid", {63'd0, msg_valid}, 64'd1);
        chk("lat_hdr_data", {31'd0, msg_last, msg_data}, {31'd0, 1'b0, c_HDR});
        wait_cnt(16'd1);
        chk("single_stop", {63'd0, stop_main_program}, 64'd1);
        drain();

        // Back-to-back pushes: no bubbles on the stream
        do_reset();
        msg_ready = 1'b1;
        push(32'd22);
        push(32'd23);
        push(32'd24);
        for (i = 0; i < 5; i++) begin
            chk("b2b_no_bubble", {63'd0, msg_valid}, 64'd1);
            tick();
        end
        drain();
        chk("b2b_count", {48'd0, msg_count}, 64'd3);

        // Fill with host stalled, then overflow attempt
        do_reset();
        msg_ready = 1'b0;
        for (i = 0; i < 4; i++) push(32'h100 + 32'(i));
        chk("full_rdy", {63'd0, echo__RDY}, 64'd0);
        chk("full_err_pre", {63'd0, proto_err}, 64'd0);
        echo__ENA = 1'b1;
        echo_v    = 32'hDEAD_BEEF;
        tick();
        echo__ENA = 1'b0;
        chk("ovf_err", {63'd0, proto_err}, 64'd1);
        chk("ovf_rdy", {63'd0, echo__RDY}, 64'd0);
        msg_ready = 1'b1;
        drain();
        chk("ovf_count", {48'd0, msg_count}, 64'd4);
        chk("ovf_err_sticky", {63'd0, proto_err}, 64'd1);

        // Random host stalls with interleaved pushes
        do_reset();
        npush = 0;
        for (i = 0; i < 120; i++) begin
            msg_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0 && echo__RDY) begin
                echo__ENA = 1'b1;
                echo_v    = $urandom;
                q.push_back({1'b0, c_HDR});
                q.push_back({1'b1, echo_v});
                npush++;
            end else begin
                echo__ENA = 1'b0;
            end
            tick();
        end
        echo__ENA = 1'b0;
        msg_ready = 1'b1;
        drain();
        chk("rand_count", {48'd0, msg_count}, 64'(npush));

        // STOP_COUNT=3 instance: stop rises on the 3rd payload and stays
        do_reset();
        for (k = 0; k < 5; k++) begin
            e3 = 1'b1;
            v3 = 32'h300 + 32'(k);
            tick();
            e3 = 1'b0;
            for (i = 0; i < 20 && count3 != 16'(k + 1); i++) tick();
            chk("stop3_count", {48'd0, count3}, 64'(k + 1));
            chk("stop3_flag", {63'd0, stop3}, (k >= 2) ? 64'd1 : 64'd0);
        end

        // Async reset while in PAY with two entries queued
        do_reset();
        msg_ready = 1'b0;
        push(32'hA1);
        push(32'hA2);
        msg_ready = 1'b1;
        tick();
        msg_ready = 1'b0;
        chk("pay_word", {31'd0, msg_valid, msg_last, msg_data}, {31'd0, 1'b1, 1'b1, 32'hA1});
        #2;
        nRST = 1'b0;
        #1;
        q.delete();
        chk("arst_valid", {63'd0, msg_valid}, 64'd0);
        chk("arst_data", {32'd0, msg_data}, 64'd0);
        chk("arst_last", {63'd0, msg_last}, 64'd0);
        chk("arst_count", {48'd0, msg_count}, 64'd0);
        tick();
        #2;
        nRST = 1'b1;
        tick();
        msg_ready = 1'b1;
        chk("arst_rdy", {63'd0, echo__RDY}, 64'd1);
        for (i = 0; i < 10; i++) begin
            tick();
            chk("arst_no_word", {63'd0, msg_valid}, 64'd0);
        end
        chk("arst_count_after", {48'd0, msg_count}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
